keypad_emulator: RTL and testbench
==================================

# keypad_emulator

Behavioural model of a 4x4 matrix keypad that answers a column-scanning keypad controller, for bench and board-level use. It watches the one-hot column drive `c3_c0` from the scanner and returns the row pattern of one simulated key on `r3_r0`, using the same key-code convention the scanner decodes. A host side requests a key press with a one-cycle strobe. The block holds the key for a programmed number of column hits, releases it for a programmed gap, then acknowledges.

## Interface
Parameters:
- `HOLD_HITS`, default 3: number of scans of the key's column during which the key reads as pressed. Legal range 1..255.
- `GAP_CYCLES`, default 4: number of clock cycles the key reads as released before `ack`. Legal range 1..255.

Ports:
- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `c3_c0` in 4: column drive from the scanner, active-high, nominally one-hot.
- `key` in 4: code of the key to press. `key[3:2]` is the row index, `key[1:0]` is the column index.
- `press` in 1: request strobe; sampled only in IDLE.
- `r3_r0` out 4: row return to the scanner, active-high.
- `busy` out 1: high from request acceptance until the gap ends.
- `ack` out 1: one-cycle pulse when a press/release sequence completes.

## Operation
- Key mapping:
  - Row `i` = `key[3:2]` (r3 = 3, r0 = 0). Column `j` = `key[1:0]` (c3 = 3, c0 = 0).
  - `ROWMASK` = 1 << i, `COLMASK` = 1 << j, both computed from the latched key.
  - Examples: key 0110 gives COLMASK 0100, ROWMASK 0010. Key 1111 gives 1000/1000. Key 0000 gives 0001/0001.
- States: IDLE, PRESS, RELEASE. State is registered; `key_r`, `hit_cnt` (8 bits) and `gap_cnt` (8 bits) are registered.
- Row output:
  - `r3_r0` = ROWMASK when state is PRESS and `c3_c0` == COLMASK exactly. Otherwise `r3_r0` = 0000.
  - A `c3_c0` value that is not one-hot, or is zero, never matches, so `r3_r0` = 0000.
- IDLE:
  - `press`=1 at an edge: `key_r`<=`key`, `hit_cnt`<=0, go to PRESS.
  - `press`=0: stay in IDLE.
- PRESS:
  - Each edge with `c3_c0` == COLMASK (a "hit") increments `hit_cnt`.
  - On the edge of hit number HOLD_HITS: `gap_cnt`<=0, go to RELEASE.
  - Cycles without a hit do not count. The key stays pressed indefinitely if its column is never scanned.
- RELEASE:
  - `gap_cnt` increments every edge.
  - On the edge where `gap_cnt` == GAP_CYCLES-1: go to IDLE and set `ack`<=1.
- Outputs:
  - `busy` = (state != IDLE), decoded from the registered state.
  - `ack` is registered. It is cleared on the edge after it is set.
- `press` while busy: ignored, not queued. `key` changes while busy: ignored, because `key_r` is latched.
- `press` in the cycle `ack`=1 (state is IDLE): accepted normally. Back-to-back sequences are therefore possible.

## Timing
- Reset values:
  - `r3_r0`=0000, `busy`=0, `ack`=0.
  - state=IDLE, `hit_cnt`=0, `gap_cnt`=0, `key_r`=0000.
- Reset asserted mid-sequence aborts it immediately (asynchronously): rows drop to 0000, no `ack` is produced. After reset deasserts, the first edge with `press`=1 starts a fresh sequence.
- Request latency: `press` sampled at edge N gives `busy`=1 after edge N. A row can respond during the cycle after edge N.
- Row response is combinational from `c3_c0`, with zero cycle latency. The scanner may sample `r3_r0` at the same edge that follows its column update.
- Release: the row goes low right after the HOLD_HITS-th hit edge, even if the column is still driven.
- Gap: exactly GAP_CYCLES cycles in RELEASE. `ack` is high for exactly 1 cycle, coincident with `busy`=0.
- Minimum sequence length: 1 + HOLD_HITS + GAP_CYCLES cycles when the column is held constant.

## Test plan
- Reset: assert `reset` between edges → all outputs are 0 immediately, with no clock edge required. Deassert, then hold `press`=0 for 10 cycles → `busy`=0, `r3_r0`=0000 throughout.
- Basic press, defaults:
  - Stimulus: `key`=0110 with a one-cycle `press`; `c3_c0` rotates 1000→0100→0010→0001 at one step per clock.
  - Required: `r3_r0`=0010 only while `c3_c0`=0100, for exactly 3 such windows. Then 0000 for 4 cycles, then a single `ack` pulse with `busy` dropping.
- Corner keys: `key`=1111 with `c3_c0`=1000 held constant → `r3_r0`=1000 for 3 cycles, then 0000. `key`=0000 with `c3_c0`=0001 → `r3_r0`=0001. Any other column value → 0000.
- Illegal columns: `c3_c0`=1100, 0000 and 1111 during PRESS for `key`=1111 → `r3_r0`=0000 and `hit_cnt` unchanged. The sequence completes only once legal hits occur.
- Ignored requests: `press` pulses and `key` changes during PRESS and RELEASE → no effect on the active key or on timing. Exactly one `ack`. A `press` in the `ack` cycle starts a new sequence on the next edge.
- Abort: assert `reset` after 2 of 3 hits → `r3_r0`=0000 at once and no `ack`. A new `press` after reset needs a full 3 hits.

Source files
------------

// File: rtl/keypad_if.sv
// Scanner/host-facing signal bundle for the keypad emulator.
// The master drives columns and requests, and the slave returns rows and status.
interface keypad_if;
   logic [3:0] c3_c0;
   logic [3:0] key;
   logic       press;
   logic [3:0] r3_r0;
   logic       busy;
   logic       ack;

   modport master (
      output c3_c0, key, press,
      input  r3_r0, busy, ack
   );

   modport slave (
      input  c3_c0, key, press,
      output r3_r0, busy, ack
   );
endinterface

// File: rtl/keypad_emulator.sv
// Simulated 4x4 matrix keypad. It holds one key for HOLD_HITS column scans,
// releases it for GAP_CYCLES cycles, and then pulses ack.
module keypad_emulator #(
   parameter int unsigned HOLD_HITS  = 3,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic    clock,
   input  logic    reset,
   keypad_if.slave io_bus
);

   localparam logic [7:0] HoldLast = 8'(HOLD_HITS - 1);
   localparam logic [7:0] GapLast  = 8'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StPress, StRelease} state_e;

   state_e     r_state, w_state_d;
   logic [3:0] r_key, w_key_d;
   logic [7:0] r_hit_cnt, w_hit_cnt_d;
   logic [7:0] r_gap_cnt, w_gap_cnt_d;
   logic       r_ack, w_ack_d;

   logic [3:0] w_colmask;
   logic [3:0] w_rowmask;
   logic       w_hit;

   assign w_colmask = 4'b0001 << r_key[1:0];
   assign w_rowmask = 4'b0001 << r_key[3:2];
   // Exact compare: zero or multi-hot column drives never count as a hit
   assign w_hit     = (r_state == StPress) && (io_bus.c3_c0 == w_colmask);

   always_comb begin
      w_state_d   = r_state;
      w_key_d     = r_key;
      w_hit_cnt_d = r_hit_cnt;
      w_gap_cnt_d = r_gap_cnt;
      w_ack_d     = 1'b0;
      case (r_state)
         StIdle: begin
            if (io_bus.press) begin
               w_key_d     = io_bus.key;
               w_hit_cnt_d = 8'd0;
               w_state_d   = StPress;
            end
         end
         StPress: begin
            if (w_hit) begin
               w_hit_cnt_d = r_hit_cnt + 8'd1;
               if (r_hit_cnt == HoldLast) begin
                  w_gap_cnt_d = 8'd0;
                  w_state_d   = StRelease;
               end
            end
         end
         StRelease: begin
            w_gap_cnt_d = r_gap_cnt + 8'd1;
            if (r_gap_cnt == GapLast) begin
               w_state_d = StIdle;
               w_ack_d   = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= StIdle;
         r_key     <= 4'b0000;
         r_hit_cnt <= 8'd0;
         r_gap_cnt <= 8'd0;
         r_ack     <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_key     <= w_key_d;
         r_hit_cnt <= w_hit_cnt_d;
         r_gap_cnt <= w_gap_cnt_d;
         r_ack     <= w_ack_d;
      end
   end

   assign io_bus.r3_r0 = w_hit ? w_rowmask : 4'b0000;
   assign io_bus.busy  = (r_state != StIdle);
   assign io_bus.ack   = r_ack;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator with the default parameters (3 hits, 4 gap cycles).
// Expected outputs are queued as each cycle's stimulus is driven and compared at the falling edge.
module tb_keypad_emulator;

   logic clock;
   logic reset;

   keypad_if bus();

   keypad_emulator #(
      .HOLD_HITS (3),
      .GAP_CYCLES(4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .io_bus(bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0] row;
      logic       busy;
      logic       ack;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Drives one cycle of inputs and queues the outputs expected for that cycle
   task automatic drive_push(input logic [3:0] c, input logic p, input logic [3:0] k,
                             input logic [3:0] row, input logic b, input logic a);
      bus.c3_c0 = c;
      bus.press = p;
      bus.key   = k;
      sb.push_back('{row: row, busy: b, ack: a});
   endtask

   task automatic test_reset();
      exp_t e;
      reset = 1'b1;
      drive_push(4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      @(negedge clock);
      e = sb.pop_front();
      n_checks++;
      if (bus.r3_r0 !== e.row || bus.busy !== e.busy || bus.ack !== e.ack) begin
         n_errors++;
         $display("FAIL reset_state: got row=%b busy=%b ack=%b, want row=%b busy=%b ack=%b",
                  bus.r3_r0, bus.busy, bus.ack, e.row, e.busy, e.ack);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         drive_push(4'b1000 >> (k % 4), 1'b0, 4'(k), 4'b0000, 1'b0, 1'b0);
         @(negedge clock);
         e = sb.pop_front();
         n_checks++;
         if (bus.r3_r0 !== e.row || bus.busy !== e.busy || bus.ack !== e.ack) begin
            n_errors++;
            $display("FAIL reset_idle cyc %0d: got row=%b busy=%b ack=%b, want row=%b busy=%b ack=%b",
                     k, bus.r3_r0, bus.busy, bus.ack, e.row, e.busy, e.ack);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_basic();
      exp_t       e;
      logic [3:0] c;
      for (int k = 0; k <= 15; k++) begin
         c = 4'b1000 >> (k % 4);
         drive_push(c, k == 0, 4'b0110,
                    (k >= 1 && k <= 9 && c == 4'b0100) ? 4'b0010 : 4'b0000,
                    k >= 1 && k <= 13, k == 14);
         @(negedge clock);
         e = sb.pop_front();
         n_checks++;
         if (bus.r3_r0 !== e.row || bus.busy !== e.busy || bus.ack !== e.ack) begin
            n_errors++;
            $display("FAIL basic cyc %0d: got row=%b busy=%b ack=%b, want row=%b busy=%b ack=%b",
                     k, bus.r3_r0, bus.busy, bus.ack, e.row, e.busy, e.ack);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_corner();
      exp_t       e;
      logic [3:0] c;
      logic [3:0] cols [0:5] = '{4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b1000, 4'b0001};
      for (int k = 0; k <= 9; k++) begin
         drive_push(4'b1000, k == 0, 4'b1111, (k >= 1 && k <= 3) ? 4'b1000 : 4'b0000,
                    k >= 1 && k <= 7, k == 8);
         @(negedge clock);
         e = sb.pop_front();
         n_checks++;
         if (bus.r3_r0 !== e.row || bus.busy !== e.busy || bus.ack !== e.ack) begin
            n_errors++;
            $display("FAIL corner_1111 cyc %0d: got row=%b busy=%b ack=%b, want row=%b busy=%b ack=%b",
                     k, bus.r3_r0, bus.busy, bus.ack, e.row, e.busy, e.ack);
         end
         @(posedge clock); #1;
      end
      for (int k = 0; k <= 12; k++) begin
         c = (k >= 1 && k <= 6) ? cols[k-1] : 4'b0001;
         drive_push(c, k == 0, 4'b0000,
                    (k >= 1 && k <= 6 && c == 4'b0001) ? 4'b0001 : 4'b0000,
                    k >= 1 && k <= 10, k == 11);
         @(negedge clock);
         e = sb.pop_front();
         n_checks++;
         if (bus.r3_r0 !== e.row || bus.busy !== e.busy || bus.ack !== e.ack) begin
            n_errors++;
            $display("FAIL corner_0000 cyc %0d: got row=%b busy=%b ack=%b, want row=%b busy=%b ack=%b",
                     k, bus.r3_r0, bus.busy, bus.ack, e.row, e.busy, e.ack);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_illegal_cols();
      exp_t       e;
      logic [3:0] c;
      logic [3:0] cols [0:8] = '{4'b0000, 4'b1100, 4'b0000, 4'b1111, 4'b1000,
                                 4'b1100, 4'b1000, 4'b0000, 4'b1000};
      for (int k = 0; k <= 14; k++) begin
         c = (k <= 8) ? cols[k] : 4'b1111;
         drive_push(c, k == 0, 4'b1111,
                    (k == 4 || k == 6 || k == 8) ? 4'b1000 : 4'b0000,
                    k >= 1 && k <= 12, k == 13);
         @(negedge clock);
         e = sb.pop_front();
         n_checks++;
         if (bus.r3_r0 !== e.row || bus.busy !== e.busy || bus.ack !== e.ack) begin
            n_errors++;
            $display("FAIL illegal_cols cyc %0d: got row=%b busy=%b ack=%b, want row=%b busy=%b ack=%b",
                     k, bus.r3_r0, bus.busy, bus.ack, e.row, e.busy, e.ack);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_ignored();
      exp_t       e;
      logic [3:0] c;
      logic       p;
      logic [3:0] kv;
      for (int k = 0; k <= 19; k++) begin
         if (k == 0) begin
            c = 4'b0001; p = 1'b1; kv = 4'b0110;
         end else if (k <= 9) begin
            // Stray requests carry key 1111, whose column is never driven here
            c  = (k % 2 == 1) ? 4'b0100 : 4'b0001;
            p  = (k == 2 || k == 4 || k == 7);
            kv = p ? 4'b1111 : 4'(k);
         end else if (k == 10) begin
            c = 4'b1000; p = 1'b1; kv = 4'b1111;
         end else begin
            c = 4'b1000; p = 1'b0; kv = 4'b0000;
         end
         drive_push(c, p, kv,
                    (k == 1 || k == 3 || k == 5) ? 4'b0010 :
                    (k >= 11 && k <= 13)         ? 4'b1000 : 4'b0000,
                    (k >= 1 && k <= 9) || (k >= 11 && k <= 17), k == 10 || k == 18);
         @(negedge clock);
         e = sb.pop_front();
         n_checks++;
         if (bus.r3_r0 !== e.row || bus.busy !== e.busy || bus.ack !== e.ack) begin
            n_errors++;
            $display("FAIL ignored_b2b cyc %0d: got row=%b busy=%b ack=%b, want row=%b busy=%b ack=%b",
                     k, bus.r3_r0, bus.busy, bus.ack, e.row, e.busy, e.ack);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_abort();
      exp_t e;
      for (int k = 0; k <= 3; k++) begin
         drive_push(4'b0100, k == 0, 4'b0110, (k >= 1) ? 4'b0010 : 4'b0000, k >= 1, 1'b0);
         @(negedge clock);
         e = sb.pop_front();
         n_checks++;
         if (bus.r3_r0 !== e.row || bus.busy !== e.busy || bus.ack !== e.ack) begin
            n_errors++;
            $display("FAIL abort_pre cyc %0d: got row=%b busy=%b ack=%b, want row=%b busy=%b ack=%b",
                     k, bus.r3_r0, bus.busy, bus.ack, e.row, e.busy, e.ack);
         end
         if (k < 3) begin
            @(posedge clock); #1;
         end
      end
      // Two hits are counted; reset lands between edges while the row is still driven
      #2;
      reset = 1'b1;
      sb.push_back('{row: 4'b0000, busy: 1'b0, ack: 1'b0});
      #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.r3_r0 !== e.row || bus.busy !== e.busy || bus.ack !== e.ack) begin
         n_errors++;
         $display("FAIL abort_immediate: got row=%b busy=%b ack=%b, want row=%b busy=%b ack=%b",
                  bus.r3_r0, bus.busy, bus.ack, e.row, e.busy, e.ack);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         drive_push(4'b0100, 1'b0, 4'b0110, 4'b0000, 1'b0, 1'b0);
         @(negedge clock);
         e = sb.pop_front();
         n_checks++;
         if (bus.r3_r0 !== e.row || bus.busy !== e.busy || bus.ack !== e.ack) begin
            n_errors++;
            $display("FAIL abort_quiet cyc %0d: got row=%b busy=%b ack=%b, want row=%b busy=%b ack=%b",
                     k, bus.r3_r0, bus.busy, bus.ack, e.row, e.busy, e.ack);
         end
         @(posedge clock); #1;
      end
      for (int k = 0; k <= 9; k++) begin
         drive_push(4'b0100, k == 0, 4'b0110, (k >= 1 && k <= 3) ? 4'b0010 : 4'b0000,
                    k >= 1 && k <= 7, k == 8);
         @(negedge clock);
         e = sb.pop_front();
         n_checks++;
         if (bus.r3_r0 !== e.row || bus.busy !== e.busy || bus.ack !== e.ack) begin
            n_errors++;
            $display("FAIL abort_restart cyc %0d: got row=%b busy=%b ack=%b, want row=%b busy=%b ack=%b",
                     k, bus.r3_r0, bus.busy, bus.ack, e.row, e.busy, e.ack);
         end
         @(posedge clock); #1;
      end
   endtask

   initial begin
      reset     = 1'b1;
      bus.c3_c0 = 4'b0000;
      bus.press = 1'b0;
      bus.key   = 4'b0000;
      test_reset();
      test_basic();
      test_corner();
      test_illegal_cols();
      test_ignored();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
